pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised IF-stage program counter and fetch unit for the MIPS32 pipeline.
//  - Holds the PC, issues sequential fetches to a synchronous instruction memory and accepts branch/jump redirects.
//  - Buffers fetched {pc, instr} pairs in a small FIFO.
//  - Presents them to ID through a valid/ready handshake, decoupling IF from ID stalls.
// PARAMETERS
//  PC_W       32  PC and memory address width
//  INSTR_W    32  instruction width
//  RESET_PC   0   PC loaded on reset
//  PC_STEP    4   sequential increment in bytes; power of 2
//  FIFO_DEPTH 4   fetch buffer entries; power of 2, >=2
// PORTS
//  clk            in   1         rising-edge clock
//  rst_n          in   1         synchronous active-low reset
//  imem_req       out  1         fetch request this cycle
//  imem_addr      out  PC_W      fetch address (= current PC)
//  imem_rdata     in   INSTR_W   instruction; valid the cycle after imem_req
//  redirect_valid in   1         branch/jump taken; 1-cycle pulse
//  redirect_pc    in   PC_W      redirect target
//  id_valid       out  1         FIFO head valid
//  id_ready       in   1         ID accepts head
//  id_pc          out  PC_W      PC of head instruction
//  id_instr       out  INSTR_W   head instruction
//  fifo_count     out  $clog2(FIFO_DEPTH)+1  occupied entries
//  misalign_fault out  1         sticky misaligned-redirect flag
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pc=RESET_PC, FIFO empty, inflight=0, state=IDLE, misalign_fault=0.
//    All outputs read 0 except imem_addr=RESET_PC.
//  - FSM:
//    - IDLE -> FETCH unconditionally; one cycle, no request.
//    - FETCH -> FAULT on a misaligned redirect (only with macro).
//    - FAULT -> FETCH on an aligned redirect.
//  - Issue: in FETCH, imem_req=1 when !redirect_valid && (fifo_count+inflight)<FIFO_DEPTH; at posedge pc<=pc+PC_STEP, inflight<=1, req_pc<=pc.
//  - Response: the cycle after issue, {req_pc, imem_rdata} is pushed unless killed; inflight clears.
//  - Throughput: 1 instr/cycle at steady state; first instr reaches id_valid 3 cycles after rst_n rises.
//  - Handshake:
//    - Pop when id_valid && id_ready.
//    - Head and id_valid are stable while id_ready=0.
//    - Push and pop in the same cycle leave count unchanged, including when full.
//  - Redirect (priority over everything):
//    - FIFO flushed (count=0, id_valid=0 next cycle).
//    - In-flight response discarded; a pop in the same cycle is still honoured for the current head.
//    - pc<=redirect_pc; no request that cycle; first request at redirect_pc next cycle.
//  - Full: no issue while count+inflight==FIFO_DEPTH, so no overflow is possible. Empty: id_valid=0 and outputs hold the last value.
//  - Arithmetic: PC increments modulo 2^PC_W (wraps from all-ones to 0, no flag); pointers wrap modulo FIFO_DEPTH.
//  - Reset mid-operation: discards FIFO contents and the in-flight fetch; a redirect in the reset cycle is ignored.
// CONFIGURATION
//  PCF_ALIGN_CHECK_EN
//  - Defined: a redirect_pc with low $clog2(PC_STEP) bits !=0 sets misalign_fault.
//    - FIFO is flushed and FSM -> FAULT (no fetches).
//    - Cleared by the next aligned redirect, which resumes normally, or by reset.
//  - Undefined: misalign_fault tied 0; low bits of redirect_pc forced to 0; FAULT state absent.
// TESTING
//  1. Reset release, id_ready=1, memory returns instr=addr^32'hFFFF0000 -> id_pc 0,4,8,C on consecutive cycles from cycle 3.
//  2. id_ready=0 for 10 cycles -> fifo_count=4, imem_req=0; id_ready=1 -> pc 0,4,8,C drain, fetch resumes at 0x10 with no gap/dup.
//  3. Redirect 0x400 while 2 queued and 1 in flight -> next cycle id_valid=0; next ID pcs 0x400,0x404; old ones never appear.
//  4. pc=32'hFFFFFFFC with PC_STEP=4 -> next fetch addr 0x0.
//  5. Redirect 0x402 with macro -> misalign_fault=1, imem_req=0; redirect 0x800 -> fault=0, fetch 0x800. Without macro -> fetch 0x400.
//  6. Assert rst_n=0 mid-stream with 3 queued -> next cycle count=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// IF-stage PC generator with a fetch buffer and valid/ready handoff to ID.
// Optional misaligned-redirect trap is enabled by defining PCF_ALIGN_CHECK_EN.
module pc_fetch_unit #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned INSTR_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned PC_STEP    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          imem_req,
    output logic [PC_W-1:0]               imem_addr,
    input  logic [INSTR_W-1:0]            imem_rdata,
    input  logic                          redirect_valid,
    input  logic [PC_W-1:0]               redirect_pc,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [PC_W-1:0]               id_pc,
    output logic [INSTR_W-1:0]            id_instr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          misalign_fault
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'(PC_STEP - 1);

`ifdef PCF_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH} state_t;
`endif

    state_t state, state_nx;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    req_pc;
    logic               inflight;
    logic [PC_W-1:0]    buf_pc    [FIFO_DEPTH];
    logic [INSTR_W-1:0] buf_instr [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [PC_W-1:0]    last_pc;
    logic [INSTR_W-1:0] last_instr;
    logic               fault;

    logic               issue, push, pop;
    logic [CW:0]        occupancy;
    logic [PC_W-1:0]    target;
`ifdef PCF_ALIGN_CHECK_EN
    logic               misalign;
    assign misalign = redirect_valid && ((redirect_pc & LOW_MASK) != '0);
    assign target   = redirect_pc;
`else
    assign target   = redirect_pc & ~LOW_MASK;
`endif

    // In-flight fetch reserves a slot so the buffer can never overflow
    assign occupancy = {1'b0, count} + (CW+1)'(inflight);
    assign push      = inflight && !redirect_valid;
    assign id_valid  = (count != '0);
    assign pop       = id_valid && id_ready;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            IDLE:  state_nx = FETCH;
            FETCH: issue = !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));
            default: state_nx = state;
        endcase
`ifdef PCF_ALIGN_CHECK_EN
        if (misalign)
            state_nx = FAULT;
        else if (redirect_valid && state == FAULT)
            state_nx = FETCH;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_pc     <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_pc    <= '0;
            last_instr <= '0;
            fault      <= 1'b0;
        end else begin
            state <= state_nx;
            if (pop) begin
                last_pc    <= buf_pc[rd_ptr];
                last_instr <= buf_instr[rd_ptr];
            end
            if (redirect_valid) begin
                pc       <= target;
                inflight <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc     <= pc + PC_W'(PC_STEP);
                    req_pc <= pc;
                end
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
`ifdef PCF_ALIGN_CHECK_EN
            if (redirect_valid)
                fault <= misalign;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= req_pc;
            buf_instr[wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req       = issue;
    assign imem_addr      = pc;
    assign fifo_count     = count;
    assign misalign_fault = fault;
    assign id_pc          = id_valid ? buf_pc[rd_ptr] : last_pc;
    assign id_instr       = id_valid ? buf_instr[rd_ptr] : last_instr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit against a program-order model.
// Build with PCF_ALIGN_CHECK_EN defined to cover the misalignment trap.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [2:0]  fifo_count;
    logic        misalign_fault;

    int errors = 0;
    int checks = 0;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_instr(id_instr),
        .fifo_count(fifo_count), .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    // synchronous instruction memory: word content derived from its address
    always @(posedge clk) imem_rdata <= imem_addr ^ 32'hFFFF0000;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!id_valid && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(id_valid), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] held_pc;
        logic        hold;
        int          pops;

        rst_n = 1'b0;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // reset state and first-fetch latency
        step();
        step();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_fault", 32'(misalign_fault), 32'd0);
        chk("rst_idpc", id_pc, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        rst_n = 1'b1;
        step();
        chk("lat_c1", 32'(id_valid), 32'd0);
        step();
        chk("lat_c2", 32'(id_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", 32'(id_valid), 32'd1);
            chk("stream_pc", id_pc, 32'(i * 4));
            chk("stream_instr", id_instr, 32'(i * 4) ^ 32'hFFFF0000);
        end

        // ID stall fills the buffer, then drains without gaps
        rst_n = 1'b0;
        id_ready = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_addr", imem_addr, 32'h10);
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("drain_valid", 32'(id_valid), 32'd1);
            chk("drain_pc", id_pc, 32'(i * 4));
            step();
        end

        // redirect with 2 queued and 1 in flight
        rst_n = 1'b0;
        id_ready = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("pre_redir_count", 32'(fifo_count), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        #1;
        chk("redir_noreq", 32'(imem_req), 32'd0);
        step();
        redirect_valid = 1'b0;
        chk("flush_valid", 32'(id_valid), 32'd0);
        chk("flush_count", 32'(fifo_count), 32'd0);
        id_ready = 1'b1;
        wait_valid("redir_timeout", 8);
        chk("redir_pc0", id_pc, 32'h400);
        step();
        chk("redir_pc1", id_pc, 32'h404);

        // PC wrap from all-ones
        redirect(32'hFFFFFFFC);
        wait_valid("wrap_timeout", 8);
        chk("wrap_pc0", id_pc, 32'hFFFFFFFC);
        step();
        chk("wrap_pc1", id_pc, 32'h0);
        chk("wrap_instr", id_instr, 32'hFFFF0000);

        // misaligned redirect
`ifdef PCF_ALIGN_CHECK_EN
        redirect(32'h402);
        chk("mis_fault", 32'(misalign_fault), 32'd1);
        chk("mis_req", 32'(imem_req), 32'd0);
        step();
        step();
        chk("mis_req_hold", 32'(imem_req), 32'd0);
        chk("mis_valid", 32'(id_valid), 32'd0);
        redirect(32'h800);
        chk("clr_fault", 32'(misalign_fault), 32'd0);
        wait_valid("clr_timeout", 8);
        chk("clr_pc", id_pc, 32'h800);
`else
        redirect(32'h402);
        chk("mis_fault", 32'(misalign_fault), 32'd0);
        wait_valid("mis_timeout", 8);
        chk("mis_pc", id_pc, 32'h400);
`endif

        // reset mid-stream, with a redirect that must be ignored
        rst_n = 1'b0;
        id_ready = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("mid_count", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h900;
        step();
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_valid", 32'(id_valid), 32'd0);
        redirect_valid = 1'b0;
        rst_n = 1'b1;
        id_ready = 1'b1;
        wait_valid("mid_timeout", 8);
        chk("mid_pc", id_pc, 32'h0);

        // random ready/redirect against the program-order model
        id_ready = 1'b0;
        redirect(32'h1000);
        exp_pc = 32'h1000;
        hold = 1'b0;
        held_pc = '0;
        pops = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold) begin
                chk("hold_valid", 32'(id_valid), 32'd1);
                chk("hold_pc", id_pc, held_pc);
            end
            id_ready = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(24) == 0);
            redirect_pc = $urandom & 32'hFFFFFFFC;
            chk("rand_count", 32'(fifo_count <= 3'd4), 32'd1);
            if (id_valid && id_ready) begin
                chk("rand_pc", id_pc, exp_pc);
                chk("rand_instr", id_instr, exp_pc ^ 32'hFFFF0000);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (redirect_valid)
                exp_pc = redirect_pc;
            hold = id_valid && !id_ready && !redirect_valid;
            held_pc = id_pc;
            step();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", 32'(pops > 500), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
